// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file: the zero-register address,
// default geometry and the 5-bit register address type.
package regfile_pkg;

    localparam int N_DEFAULT    = 64;
    localparam int NREG_DEFAULT = 32;

    typedef logic [4:0] reg_addr_t;

    localparam reg_addr_t ZR_ADDR = 5'd31;

    function automatic logic is_zr(input reg_addr_t addr);
        return (addr == ZR_ADDR);
    endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: selects a stored register, forces XZR to zero and
// forwards in-flight write data when the write targets the same address.
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int N    = N_DEFAULT,
    parameter int NREG = NREG_DEFAULT
) (
    input  reg_addr_t        addr_i,
    input  logic [N-1:0]     regs_i [0:NREG-2],
    input  logic             byp_en_i,
    input  reg_addr_t        byp_addr_i,
    input  logic [N-1:0]     byp_data_i,
    output logic [N-1:0]     data_o
);

    logic [N-1:0] stored_s;

    // Select the addressed storage entry; unmatched addresses fall through to zero.
    always_comb begin
        stored_s = {N{1'b0}};
        for (int i = 0; i < NREG - 1; i++) begin
            stored_s = (addr_i == reg_addr_t'(i)) ? regs_i[i] : stored_s;
        end
    end

    // XZR masking has priority so a discarded write to X31 can never leak through.
    always_comb begin
        data_o = {N{1'b0}};
        if (is_zr(addr_i)) begin
            data_o = {N{1'b0}};
        end else if (byp_en_i && (byp_addr_i == addr_i)) begin
            data_o = byp_data_i;
        end else begin
            data_o = stored_s;
        end
    end

endmodule

// File: rtl/regfile.sv
// Register file with two combinational read ports, one write port, write-first
// bypass, a hard-wired zero register X31 and reset values Xi = i.
module regfile
    import regfile_pkg::*;
#(
    parameter int N    = N_DEFAULT,
    parameter int NREG = NREG_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we3,
    input  logic [4:0]       ra1,
    input  logic [4:0]       ra2,
    input  logic [4:0]       wa3,
    input  logic [N-1:0]     wd3,
    output logic [N-1:0]     rd1,
    output logic [N-1:0]     rd2
);

    logic [N-1:0] regs_q [0:NREG-2];
    logic [N-1:0] regs_d [0:NREG-2];
    logic         wr_en_s;

    // A write is live only outside reset and when it does not target XZR.
    always_comb begin
        wr_en_s = we3 & ~reset & ~is_zr(wa3);
    end

    // Next-state for the array: only the addressed entry takes the write data.
    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NREG - 1; i++) begin
            if (wr_en_s && (wa3 == reg_addr_t'(i))) begin
                regs_d[i] = wd3;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    // Storage; reset overrides any simultaneous write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG - 1; i++) begin
                regs_q[i] <= N'(i);
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_rdport #(.N(N), .NREG(NREG)) u_rdport1 (
        .addr_i     (ra1),
        .regs_i     (regs_q),
        .byp_en_i   (wr_en_s),
        .byp_addr_i (wa3),
        .byp_data_i (wd3),
        .data_o     (rd1)
    );

    regfile_rdport #(.N(N), .NREG(NREG)) u_rdport2 (
        .addr_i     (ra2),
        .regs_i     (regs_q),
        .byp_en_i   (wr_en_s),
        .byp_addr_i (wa3),
        .byp_data_i (wd3),
        .data_o     (rd2)
    );

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: expected values are queued when stimulus is driven
// and popped in order when the DUT outputs are sampled.
module tb_regfile;

    localparam int N = 64;

    logic         clk;
    logic         reset;
    logic         we3;
    logic [4:0]   ra1;
    logic [4:0]   ra2;
    logic [4:0]   wa3;
    logic [N-1:0] wd3;
    logic [N-1:0] rd1;
    logic [N-1:0] rd2;

    typedef struct {
        string        tag;
        logic [N-1:0] val;
    } sb_t;

    sb_t          sb_q[$];
    logic [N-1:0] model [0:30];
    int           errors = 0;
    int           checks = 0;
    logic [N-1:0] alu_y;
    logic [N-1:0] zflag;

    regfile #(.N(N), .NREG(32)) dut (
        .clk   (clk),
        .reset (reset),
        .we3   (we3),
        .ra1   (ra1),
        .ra2   (ra2),
        .wa3   (wa3),
        .wd3   (wd3),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N-1:0] alu(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic [3:0] op);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            default: return {N{1'b0}};
        endcase
    endfunction

    task automatic expect_val(input string tag, input logic [N-1:0] v);
        sb_t e;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic compare(input logic [N-1:0] obs);
        sb_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 31; i++) model[i] = 64'(i);
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [N-1:0] d);
        @(negedge clk);
        we3 = 1'b1; wa3 = a; wd3 = d;
        if (a != 5'd31) model[a] = d;
        tick();
        @(negedge clk);
        we3 = 1'b0;
    endtask

    initial begin
        reset = 1'b0; we3 = 1'b0; ra1 = 5'd0; ra2 = 5'd0; wa3 = 5'd0; wd3 = 64'h0;

        // Reset values
        @(negedge clk);
        reset = 1'b1;
        tick();
        model_reset();
        @(negedge clk);
        reset = 1'b0; ra1 = 5'd5; ra2 = 5'd30;
        expect_val("reset_x5", 64'h5);
        expect_val("reset_x30", 64'h1E);
        tick(); compare(rd1); compare(rd2);
        @(negedge clk);
        ra1 = 5'd31; ra2 = 5'd0;
        expect_val("reset_xzr", 64'h0);
        expect_val("reset_x0", 64'h0);
        tick(); compare(rd1); compare(rd2);

        // Plain write then read
        write_reg(5'd3, 64'h12345678);
        ra1 = 5'd3; ra2 = 5'd4;
        expect_val("wr_x3", 64'h12345678);
        expect_val("wr_x4_unchanged", 64'h4);
        tick(); compare(rd1); compare(rd2);

        // Full-width value with the MSB set
        write_reg(5'd30, 64'h8000_0000_0000_0001);
        ra1 = 5'd30; ra2 = 5'd29;
        expect_val("wr_x30_full", 64'h8000_0000_0000_0001);
        expect_val("wr_x29_unchanged", 64'h1D);
        tick(); compare(rd1); compare(rd2);

        // Writes to XZR vanish; sweep every register against the model
        write_reg(5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
        ra1 = 5'd31; ra2 = 5'd31;
        expect_val("xzr_rd1", 64'h0);
        expect_val("xzr_rd2", 64'h0);
        tick(); compare(rd1); compare(rd2);
        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            ra1 = 5'(i); ra2 = 5'(30 - i);
            expect_val($sformatf("sweep_rd1_x%0d", i), model[i]);
            expect_val($sformatf("sweep_rd2_x%0d", 30 - i), model[30 - i]);
            tick(); compare(rd1); compare(rd2);
        end

        // Write-first bypass before the edge, both ports on the same address
        @(negedge clk);
        we3 = 1'b1; wa3 = 5'd7; wd3 = 64'hABCD1459; ra1 = 5'd7; ra2 = 5'd7;
        expect_val("byp_rd1", 64'hABCD1459);
        expect_val("byp_rd2", 64'hABCD1459);
        #1; compare(rd1); compare(rd2);
        ra2 = 5'd8;
        expect_val("byp_other_port", model[8]);
        #1; compare(rd2);
        model[7] = 64'hABCD1459;
        tick();
        @(negedge clk);
        we3 = 1'b0; wd3 = 64'h0;
        expect_val("byp_persist", 64'hABCD1459);
        tick(); compare(rd1);

        // we3=0 with live address/data must not modify anything
        @(negedge clk);
        wa3 = 5'd7; wd3 = 64'h5555_5555_5555_5555;
        tick();
        expect_val("we0_hold", 64'hABCD1459);
        compare(rd1);

        // During reset, reads show stored data and bypass is off
        @(negedge clk);
        reset = 1'b1; we3 = 1'b1; wa3 = 5'd3; wd3 = 64'hDEADBEEF; ra1 = 5'd3; ra2 = 5'd7;
        expect_val("rst_nobyp_x3", model[3]);
        expect_val("rst_stored_x7", model[7]);
        #1; compare(rd1); compare(rd2);
        tick();
        model_reset();
        expect_val("rst_wins_x3", 64'h3);
        expect_val("rst_clears_x7", 64'h7);
        compare(rd1); compare(rd2);

        // Reset priority on X9
        @(negedge clk);
        reset = 1'b1; we3 = 1'b1; wa3 = 5'd9; wd3 = 64'hDEADBEEF;
        tick();
        @(negedge clk);
        reset = 1'b0; we3 = 1'b0; ra1 = 5'd9; ra2 = 5'd30;
        expect_val("rst_prio_x9", 64'h9);
        expect_val("rst_x30_restored", 64'h1E);
        tick(); compare(rd1); compare(rd2);

        // Operands feeding a subtract
        write_reg(5'd1, 64'h000FF000);
        write_reg(5'd2, 64'h0FF00000);
        ra1 = 5'd1; ra2 = 5'd2;
        tick();
        alu_y = alu(rd1, rd2, 4'b0110);
        zflag = {63'h0, (alu_y == 64'h0)};
        expect_val("alu_sub_y", 64'hFFFFFFFFF01FF000);
        expect_val("alu_zero", 64'h0);
        compare(alu_y); compare(zflag);

        if (sb_q.size() != 0) begin
            errors++;
            checks++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
